// File: rtl/top_sched_pkg.sv
// Shared types and defaults for the two-requester operation scheduler.
package top_sched_pkg;

  localparam int W_DEF   = 12;
  localparam int LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a tie;
// a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  // one-hot grant, or zero when nobody is requesting
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/top_sched.sv
// Shares one pipelined datapath between two requesters. One operation is in
// flight at a time: accept, issue a one-cycle enable, wait LAT cycles, then
// present the captured result for one cycle.
//
//   state | meaning
//   IDLE  | ready to accept one request via round-robin
//   ISSUE | operands on dp_a/b/c, dp_e high for this cycle
//   WAIT  | datapath busy, down-counter runs from LAT to 1
//   RESP  | rsp_valid high, priority pointer moves past the owner
module top_sched
  import top_sched_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] c0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] c1,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic [W-1:0] dp_c,
  output logic         dp_e,
  input  logic [W-1:0] dp_y,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       ptr;
  logic       gid;
  logic [1:0] grant;
  logic       xfer;
  logic       wait_done;

  rr_arb2 u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (grant)
  );

  // grants are only offered from IDLE and never while reset is held
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst) begin
      req_ready = grant;
    end
  end

  assign xfer      = |req_ready;
  assign wait_done = (state == WAIT) && (cnt == 4'd1);

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register plus the registered strobes derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dp_e      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      dp_e      <= (state_nxt == ISSUE);
      rsp_valid <= (state_nxt == RESP);
    end
  end

  // operand capture on a transfer; held untouched until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
      dp_c <= '0;
      gid  <= 1'b0;
    end else if (xfer) begin
      gid  <= req_ready[1];
      dp_a <= req_ready[1] ? a1 : a0;
      dp_b <= req_ready[1] ? b1 : b0;
      dp_c <= req_ready[1] ? c1 : c0;
    end
  end

  // WAIT timer: loaded with LAT leaving ISSUE, terminal count at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (state == ISSUE) begin
      cnt <= LAT_CNT;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // result capture on the final WAIT edge, so rsp_id/rsp_y change only entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y  <= '0;
      rsp_id <= 1'b0;
    end else if (wait_done) begin
      rsp_y  <= dp_y;
      rsp_id <= gid;
    end
  end

  // priority moves to the other requester once the result is delivered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == RESP) begin
      ptr <= ~gid;
    end
  end

endmodule

// File: tb/tb_top_sched.sv
// Randomized bench for top_sched at LAT = 2, 1 and 15. Each instance has an
// XOR datapath stub and a timestamp-based reference: a transfer at cycle t
// predicts dp_e at t+1, the response at t+2+LAT and the next grant at t+3+LAT.
module tb_top_sched;

  localparam int NCYC = 1200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // tie goes to the requester not granted last; a lone requester wins
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [11:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
    logic [11:0] dp_a, dp_b, dp_c, dp_y, rsp_y;
    logic        dp_e, rsp_valid, rsp_id;
    logic [11:0] pipe [16];
    bit          done = 1'b0;

    top_sched #(.W(12), .LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a0        (a0),
      .b0        (b0),
      .c0        (c0),
      .a1        (a1),
      .b1        (b1),
      .c1        (c1),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_c      (dp_c),
      .dp_e      (dp_e),
      .dp_y      (dp_y),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y)
    );

    // datapath stub: a^b^c appears LAT cycles after the dp_e cycle
    always @(posedge clk) begin
      pipe[0] <= dp_e ? (dp_a ^ dp_b ^ dp_c) : 12'h000;
      for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
    end
    assign dp_y = pipe[L-1];

    initial begin : drv
      int          t, gid, last, pb, p0, p1;
      bit          busy, in_rst, first, exp_e, exp_rv;
      logic [11:0] ea, eb, ec, ey, ry;
      logic        rid;
      logic [1:0]  rdy_exp, drop;
      string       pfx;

      t = 0; gid = 0; last = 1; busy = 0; in_rst = 1; first = 1;
      ea = '0; eb = '0; ec = '0; ey = '0; ry = '0; rid = 1'b0; drop = 2'b00;
      pb = 4 * (L + 3) + 4;
      pfx = $sformatf("L%0d ", L);
      repeat (2) @(negedge clk);

      for (int n = 0; n < NCYC; n++) begin
        @(negedge clk);
        if (in_rst) begin
          rst = 1'b0;
          in_rst = 0;
        end
        req_valid = req_valid & ~drop;
        drop = 2'b00;
        p0 = (n < pb) ? 100 : 30;
        p1 = (n < pb) ? 100 : 55;
        if (!req_valid[0] && $urandom_range(99) < p0) begin
          req_valid[0] = 1'b1;
          if (first && L == 2) begin
            a0 = 12'hDFC; b0 = 12'h5B4; c0 = 12'h0E7;
          end else begin
            a0 = 12'($urandom); b0 = 12'($urandom); c0 = 12'($urandom);
          end
          first = 0;
        end
        if (!req_valid[1] && $urandom_range(99) < p1) begin
          req_valid[1] = 1'b1;
          a1 = 12'($urandom); b1 = 12'($urandom); c1 = 12'($urandom);
        end
        #1;

        rdy_exp = busy ? 2'b00 : rr_pick(req_valid, last);
        exp_e   = busy && (n == t + 1);
        exp_rv  = busy && (n == t + 2 + L);
        if (exp_rv) begin
          ry  = ey;
          rid = gid[0];
        end
        chk({pfx, "req_ready"}, 32'(req_ready), 32'(rdy_exp));
        chk({pfx, "dp_e"},      32'(dp_e),      32'(exp_e));
        chk({pfx, "rsp_valid"}, 32'(rsp_valid), 32'(exp_rv));
        chk({pfx, "rsp_id"},    32'(rsp_id),    32'(rid));
        chk({pfx, "rsp_y"},     32'(rsp_y),     32'(ry));
        chk({pfx, "dp_a"},      32'(dp_a),      32'(ea));
        chk({pfx, "dp_b"},      32'(dp_b),      32'(eb));
        chk({pfx, "dp_c"},      32'(dp_c),      32'(ec));

        if (exp_rv) begin
          busy = 0;
          last = gid;
        end else if (!busy && rdy_exp != 2'b00) begin
          busy = 1;
          t    = n;
          gid  = rdy_exp[1] ? 1 : 0;
          ea   = rdy_exp[1] ? a1 : a0;
          eb   = rdy_exp[1] ? b1 : b0;
          ec   = rdy_exp[1] ? c1 : c0;
          ey   = ea ^ eb ^ ec;
          drop = rdy_exp;
        end

        if (n >= pb && $urandom_range(busy ? 24 : 99) == 0) begin
          rst = 1'b1;
          #1;
          chk({pfx, "rst req_ready"}, 32'(req_ready), 32'd0);
          chk({pfx, "rst dp_e"},      32'(dp_e),      32'd0);
          chk({pfx, "rst rsp_valid"}, 32'(rsp_valid), 32'd0);
          chk({pfx, "rst rsp_id"},    32'(rsp_id),    32'd0);
          chk({pfx, "rst rsp_y"},     32'(rsp_y),     32'd0);
          chk({pfx, "rst dp_abc"},    32'(dp_a | dp_b | dp_c), 32'd0);
          busy = 0; last = 1; drop = 2'b00;
          ea = '0; eb = '0; ec = '0; ry = '0; rid = 1'b0;
          in_rst = 1;
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < NCYC + 200; k++) begin
      @(posedge clk);
      if (u[0].done && u[1].done && u[2].done) break;
    end
    chk("all instances finished", 32'(u[0].done & u[1].done & u[2].done), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
